// File: rtl/registerfile_pkg.sv
// rtl/registerfile_pkg.sv - shared register file constants and write-port ids
package registerfile_pkg;

    localparam int RF_DATA_W = 16;
    localparam int RF_ADDR_W = 4;

    // Write-port ids; a higher id has priority when both ports hit one address
    localparam int WP_ALU    = 0;
    localparam int WP_LOAD   = 1;
    localparam int NUM_WP    = 2;

endpackage

// File: rtl/registerfile_mp_scoreboard.sv
// rtl/registerfile_mp_scoreboard.sv - pending-write busy bits with registered lookups
module rf_scoreboard #(
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_addr,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              busy_a,
    output logic              busy_b
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] busy_d, busy_q;
    logic             busy_a_d, busy_a_q;
    logic             busy_b_d, busy_b_q;

    // Next busy state: writes clear, issue sets (set applied last so it wins)
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            if ((we0 && wa0 == ADDR_W'(i)) || (we1 && wa1 == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (busy_set && busy_addr == ADDR_W'(i)) begin
                busy_d[i] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
        busy_a_d = busy_d[rs1];
        busy_b_d = busy_d[rs2];
    end

    // Busy state and lookup registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q   <= '0;
            busy_a_q <= 1'b0;
            busy_b_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            busy_a_q <= busy_a_d;
            busy_b_q <= busy_b_d;
        end
    end

    assign busy_a = busy_a_q;
    assign busy_b = busy_b_q;

endmodule

// File: rtl/registerfile_mp.sv
// rtl/registerfile_mp.sv - dual-write dual-read register file with busy tracking
module registerfile_mp
    import registerfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] RS1,
    input  logic [ADDR_W-1:0] RS2,
    input  logic              WE0,
    input  logic [ADDR_W-1:0] WA0,
    input  logic [DATA_W-1:0] WD0,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] WA1,
    input  logic [DATA_W-1:0] WD1,
    input  logic              BUSY_SET,
    input  logic [ADDR_W-1:0] BUSY_ADDR,
    output logic [DATA_W-1:0] REG_A,
    output logic [DATA_W-1:0] REG_B,
    output logic              BUSY_A,
    output logic              BUSY_B
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [NUM_WP-1:0]             wp_we;
    logic [NUM_WP-1:0][ADDR_W-1:0] wp_addr;
    logic [NUM_WP-1:0][DATA_W-1:0] wp_data;

    logic [DEPTH-1:0][DATA_W-1:0]  rf_d, rf_q;
    logic [DEPTH-1:0][DATA_W-1:0]  read_src;
    logic [DATA_W-1:0]             reg_a_d, reg_a_q;
    logic [DATA_W-1:0]             reg_b_d, reg_b_q;

    // Gather write ports by id so the priority loop below stays port-agnostic
    always_comb begin
        wp_we            = '0;
        wp_addr          = '0;
        wp_data          = '0;
        wp_we[WP_ALU]    = WE0;
        wp_addr[WP_ALU]  = WA0;
        wp_data[WP_ALU]  = WD0;
        wp_we[WP_LOAD]   = WE1;
        wp_addr[WP_LOAD] = WA1;
        wp_data[WP_LOAD] = WD1;
    end

    // Post-write contents and read data; ascending port order lets the load port win
    always_comb begin
        rf_d = rf_q;
        for (int p = 0; p < NUM_WP; p++) begin
            if (wp_we[p] && !(ZERO_REG != 0 && wp_addr[p] == '0)) begin
                rf_d[wp_addr[p]] = wp_data[p];
            end
        end
        read_src = (BYPASS != 0) ? rf_d : rf_q;
        reg_a_d  = read_src[RS1];
        reg_b_d  = read_src[RS2];
        if (ZERO_REG != 0 && RS1 == '0) begin
            reg_a_d = '0;
        end
        if (ZERO_REG != 0 && RS2 == '0) begin
            reg_b_d = '0;
        end
    end

    // Storage array and registered read ports with synchronous reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rf_q    <= '0;
            reg_a_q <= '0;
            reg_b_q <= '0;
        end else begin
            rf_q    <= rf_d;
            reg_a_q <= reg_a_d;
            reg_b_q <= reg_b_d;
        end
    end

    assign REG_A = reg_a_q;
    assign REG_B = reg_b_q;

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (CLK),
        .rst_n     (RST_N),
        .we0       (WE0),
        .wa0       (WA0),
        .we1       (WE1),
        .wa1       (WA1),
        .busy_set  (BUSY_SET),
        .busy_addr (BUSY_ADDR),
        .rs1       (RS1),
        .rs2       (RS2),
        .busy_a    (BUSY_A),
        .busy_b    (BUSY_B)
    );

endmodule

// File: tb/tb_registerfile_mp.sv
// tb/tb_registerfile_mp.sv - directed self-checking bench for registerfile_mp
`timescale 1ns/1ps
module tb_registerfile_mp;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [3:0]  RS1, RS2, WA0, WA1, BUSY_ADDR;
    logic        WE0, WE1, BUSY_SET;
    logic [15:0] WD0, WD1;
    logic [15:0] REG_A, REG_B, nb_reg_a, nb_reg_b;
    logic        BUSY_A, BUSY_B, nb_busy_a, nb_busy_b;

    int n_pass  = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    registerfile_mp #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) dut (
        .CLK(CLK), .RST_N(RST_N), .RS1(RS1), .RS2(RS2),
        .WE0(WE0), .WA0(WA0), .WD0(WD0), .WE1(WE1), .WA1(WA1), .WD1(WD1),
        .BUSY_SET(BUSY_SET), .BUSY_ADDR(BUSY_ADDR),
        .REG_A(REG_A), .REG_B(REG_B), .BUSY_A(BUSY_A), .BUSY_B(BUSY_B)
    );

    registerfile_mp #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .CLK(CLK), .RST_N(RST_N), .RS1(RS1), .RS2(RS2),
        .WE0(WE0), .WA0(WA0), .WD0(WD0), .WE1(WE1), .WA1(WA1), .WD1(WD1),
        .BUSY_SET(BUSY_SET), .BUSY_ADDR(BUSY_ADDR),
        .REG_A(nb_reg_a), .REG_B(nb_reg_b), .BUSY_A(nb_busy_a), .BUSY_B(nb_busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        WE0 = 1'b0; WA0 = '0; WD0 = '0;
        WE1 = 1'b0; WA1 = '0; WD1 = '0;
        BUSY_SET = 1'b0; BUSY_ADDR = '0;
    endtask

    // Apply current inputs for one rising edge, then settle just past it
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N = 1'b0; RS1 = '0; RS2 = '0;
        idle();
        step();
        check("rst_reg_a", REG_A, 16'h0000);
        check("rst_reg_b", REG_B, 16'h0000);
        check("rst_busy_a", BUSY_A, 1'b0);
        check("rst_busy_b", BUSY_B, 1'b0);

        // Preload R3 then reset it away; writes and busy set during reset are dropped
        RST_N = 1'b1;
        WE0 = 1'b1; WA0 = 4'd3; WD0 = 16'h1234;
        step();
        idle(); RS1 = 4'd3;
        step();
        check("preload_r3", REG_A, 16'h1234);
        RST_N = 1'b0;
        WE0 = 1'b1; WA0 = 4'd3; WD0 = 16'h5555;
        BUSY_SET = 1'b1; BUSY_ADDR = 4'd3;
        step();
        check("rst_mid_reg_a", REG_A, 16'h0000);
        RST_N = 1'b1; idle();
        step();
        check("post_rst_r3", REG_A, 16'h0000);
        check("post_rst_busy3", BUSY_A, 1'b0);

        // Plain write then read a cycle later
        WE0 = 1'b1; WA0 = 4'd5; WD0 = 16'hBEEF;
        step();
        idle(); RS2 = 4'd5;
        step();
        check("wr_rd_r5", REG_B, 16'hBEEF);
        check("wr_rd_r5_nb", nb_reg_b, 16'hBEEF);

        // Same-cycle bypass from the load port
        WE1 = 1'b1; WA1 = 4'd7; WD1 = 16'h00AA; RS1 = 4'd7;
        step();
        check("byp_r7", REG_A, 16'h00AA);
        check("byp_r7_nb", nb_reg_a, 16'h0000);
        idle();
        step();
        check("r7_after", REG_A, 16'h00AA);
        check("r7_after_nb", nb_reg_a, 16'h00AA);

        // Same-cycle bypass from the ALU port on read port B
        WE0 = 1'b1; WA0 = 4'd6; WD0 = 16'h3333; RS2 = 4'd6;
        step();
        check("byp_r6_b", REG_B, 16'h3333);
        check("byp_r6_b_nb", nb_reg_b, 16'h0000);
        idle();

        // Both ports hit R4: load port wins
        WE0 = 1'b1; WA0 = 4'd4; WD0 = 16'h1111;
        WE1 = 1'b1; WA1 = 4'd4; WD1 = 16'h2222; RS1 = 4'd4;
        step();
        check("coll_byp", REG_A, 16'h2222);
        idle();
        step();
        check("coll_r4", REG_A, 16'h2222);
        check("coll_r4_nb", nb_reg_a, 16'h2222);

        // Zero register ignores writes and busy set
        WE0 = 1'b1; WA0 = 4'd0; WD0 = 16'hFFFF;
        WE1 = 1'b1; WA1 = 4'd0; WD1 = 16'hEEEE;
        BUSY_SET = 1'b1; BUSY_ADDR = 4'd0; RS1 = 4'd0;
        step();
        check("zero_byp", REG_A, 16'h0000);
        check("zero_busy_byp", BUSY_A, 1'b0);
        idle();
        step();
        check("zero_reg_a", REG_A, 16'h0000);
        check("zero_busy_a", BUSY_A, 1'b0);

        // Scoreboard: set, set-vs-clear, clear
        BUSY_SET = 1'b1; BUSY_ADDR = 4'd9; RS1 = 4'd9; RS2 = 4'd5;
        step();
        check("sb_set_byp", BUSY_A, 1'b1);
        check("sb_other_b", BUSY_B, 1'b0);
        check("sb_set_nb", nb_busy_a, 1'b1);
        idle(); RS2 = 4'd9;
        step();
        check("sb_hold_a", BUSY_A, 1'b1);
        check("sb_hold_b", BUSY_B, 1'b1);
        BUSY_SET = 1'b1; BUSY_ADDR = 4'd9;
        WE1 = 1'b1; WA1 = 4'd9; WD1 = 16'h0909;
        step();
        check("sb_setwins", BUSY_A, 1'b1);
        check("sb_setwins_data", REG_A, 16'h0909);
        idle();
        step();
        check("sb_still", BUSY_A, 1'b1);
        WE0 = 1'b1; WA0 = 4'd9; WD0 = 16'h9999;
        step();
        check("sb_clear", BUSY_A, 1'b0);
        check("sb_clear_b", BUSY_B, 1'b0);
        idle();

        // Reset drops pending busy bits
        BUSY_SET = 1'b1; BUSY_ADDR = 4'd10; RS1 = 4'd10;
        step();
        check("sb_r10_set", BUSY_A, 1'b1);
        idle(); RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        step();
        check("sb_r10_rst", BUSY_A, 1'b0);
        check("r9_rst_data", REG_B, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
